mfcc_frame_scheduler: RTL and testbench
=======================================

# mfcc_frame_scheduler

Sequences the Hamming-window stage of the MFCC front end. Buffers the incoming audio sample stream in a circular RAM, cuts it into overlapping frames (FRAME_LEN samples, advancing HOP_LEN per frame), starts the window stage, serves its sample reads, and waits for its done before advancing to the next frame. Sits between the audio capture FIFO and the windowing block.

## Interface
- SAMPLE_WIDTH, 16, audio sample width
- FRAME_LEN, 306, samples per frame; equals the window stage's coefficient count
- HOP_LEN, 128, frame advance in samples; 1 ≤ HOP_LEN ≤ FRAME_LEN
- BUF_DEPTH, 1024, circular buffer depth; power of two, ≥ FRAME_LEN + HOP_LEN
- ADDR_W, $clog2(BUF_DEPTH), buffer address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable_i  in  1  run scheduler; low flushes the buffer once idle
- clear_i  in  1  one-cycle pulse that clears overrun_o
- sample_i  in  SAMPLE_WIDTH  signed audio sample
- sample_valid_i  in  1  sample_i valid this cycle; there is no backpressure
- win_start_o  out  1  one-cycle start pulse to the window stage
- win_rd_en_i  in  1  window stage requests samples
- win_valid_to_read_o  out  1  win_sample_o valid this cycle
- win_sample_o  out  SAMPLE_WIDTH  frame sample, in frame order
- win_done_i  in  1  window stage finished the frame
- busy_o  out  1  state is not IDLE
- frame_count_o  out  16  completed frames; wraps at 2^16
- overrun_o  out  1  sticky; a sample was dropped because the buffer was full

## Operation
- Write side, in every state except while enable_i = 0 in IDLE: on sample_valid_i, write buf[wr_ptr] and increment wr_ptr modulo BUF_DEPTH. avail is the count of unconsumed samples from base, range 0..BUF_DEPTH, and increments on each write.
- If avail == BUF_DEPTH, drop the sample, leave wr_ptr and avail unchanged, and set overrun_o. clear_i clears overrun_o. If clear_i and a new overrun occur in the same cycle, overrun_o stays set.
- FSM states: IDLE, WAIT_FILL, START, SERVE, WAIT_DONE, ADVANCE.
- IDLE: when enable_i = 1, go to WAIT_FILL. While enable_i = 0, hold base = wr_ptr = avail = 0.
- WAIT_FILL: when avail ≥ FRAME_LEN, go to START. If enable_i = 0, go to IDLE, which flushes the buffer.
- START: assert win_start_o for one cycle, set offset = 0, then go to SERVE.
- SERVE: in each cycle with win_rd_en_i = 1 and offset < FRAME_LEN, read buf[(base + offset) mod BUF_DEPTH] and increment offset. When offset reaches FRAME_LEN, go to WAIT_DONE. A cycle with win_rd_en_i = 0 pauses issue.
- WAIT_DONE: on win_done_i, increment frame_count_o and go to ADVANCE. A win_done_i outside WAIT_DONE is ignored.
- ADVANCE: base += HOP_LEN (mod BUF_DEPTH) and avail -= HOP_LEN. A write in the same cycle gives avail − HOP_LEN + 1. Then go to WAIT_FILL. enable_i = 0 is honoured only in WAIT_FILL, so a started frame always completes.
- The read address never equals the write address in the same cycle, because avail ≥ FRAME_LEN while serving. No read-during-write rule is needed.

## Timing
- Reset values: win_start_o = 0, win_valid_to_read_o = 0, win_sample_o = 0, busy_o = 0, frame_count_o = 0, overrun_o = 0. Internal state: IDLE, base = wr_ptr = avail = offset = 0.
- Write latency: a sample written at edge N is counted in avail from edge N.
- avail reaching FRAME_LEN at edge N puts the FSM in START at N+1, with win_start_o high during the N+1..N+2 cycle.
- Synchronous RAM: a read issued in cycle k gives win_valid_to_read_o = 1 and data in cycle k+1.
- Exactly FRAME_LEN valid cycles occur per frame, and at most one sample per cycle.
- After the last read, WAIT_DONE is entered on the next edge. The final valid beat coincides with the first WAIT_DONE cycle.
- Back-to-back frames: win_done_i to the next win_start_o takes 3 cycles minimum (ADVANCE, WAIT_FILL, START) when data is available.
- An asynchronous rst_n mid-frame returns everything to reset values immediately and discards all buffered data.

## Test plan
- Fill: with defaults, stream 306 samples of value i → win_start_o pulses once. Then drive rd_en continuously → 306 valid beats with data 0..305 in order, and busy_o stays 1 until done.
- Hop: stream 700 samples and ack each frame with done → 3 frames complete. Frame 2 starts at sample 128 and frame 3 at sample 256. frame_count_o = 3 and avail = 700 − 384 = 316.
- Wrap: stream 2000 samples while consuming → a frame whose base is 896 returns samples crossing address 1023→0 with correct values, and overrun_o stays 0.
- Overrun: stream 1030 samples without acking done → exactly 6 samples are dropped and overrun_o = 1. A clear_i pulse → 0. An overrun coinciding with clear_i → remains 1.
- Throttle: toggle rd_en 1/0 each cycle → 306 valid beats with no duplicates or skips. Drop enable_i mid-frame → the frame completes, then the FSM goes to IDLE and avail = 0.
- Reset: assert rst_n low mid-SERVE → all outputs are 0 immediately. After release, the next frame starts from fresh samples.

Source files
------------

// File: rtl/mfcc_frame_scheduler.sv
// Frame scheduler for the MFCC Hamming-window stage.
// Buffers the audio stream in a circular RAM, cuts overlapping frames of
// FRAME_LEN samples advancing by HOP_LEN, and serves them to the window stage.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | disabled; buffer held empty, writes ignored while enable low
// WAIT_FILL | waiting for FRAME_LEN unconsumed samples
// START     | one-cycle start pulse to the window stage, offset cleared
// SERVE     | issuing frame reads on each win_rd_en_i cycle
// WAIT_DONE | all reads issued, waiting for the window stage's done
// ADVANCE   | base moves on by HOP_LEN, avail drops by HOP_LEN
module mfcc_frame_scheduler #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int FRAME_LEN    = 306,
   parameter int HOP_LEN      = 128,
   parameter int BUF_DEPTH    = 1024,
   parameter int ADDR_W       = $clog2(BUF_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable_i,
   input  logic                    clear_i,
   input  logic [SAMPLE_WIDTH-1:0] sample_i,
   input  logic                    sample_valid_i,
   output logic                    win_start_o,
   input  logic                    win_rd_en_i,
   output logic                    win_valid_to_read_o,
   output logic [SAMPLE_WIDTH-1:0] win_sample_o,
   input  logic                    win_done_i,
   output logic                    busy_o,
   output logic [15:0]             frame_count_o,
   output logic                    overrun_o
);

   localparam int AVAIL_W = ADDR_W + 1;
   localparam int OFF_W   = $clog2(FRAME_LEN + 1);

   localparam logic [AVAIL_W-1:0] AVAIL_FULL  = AVAIL_W'(BUF_DEPTH);
   localparam logic [AVAIL_W-1:0] AVAIL_FRAME = AVAIL_W'(FRAME_LEN);
   localparam logic [AVAIL_W-1:0] AVAIL_HOP   = AVAIL_W'(HOP_LEN);
   localparam logic [ADDR_W-1:0]  ADDR_HOP    = ADDR_W'(HOP_LEN);
   localparam logic [OFF_W-1:0]   OFF_LAST    = OFF_W'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_FILL = 3'd1,
      START     = 3'd2,
      SERVE     = 3'd3,
      WAIT_DONE = 3'd4,
      ADVANCE   = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]         base_q, base_d;
   logic [AVAIL_W-1:0]        avail_q, avail_d;
   logic [OFF_W-1:0]          offset_q, offset_d;
   logic [15:0]               frame_count_q, frame_count_d;
   logic                      overrun_q, overrun_d;
   logic                      rd_valid_q;
   logic [SAMPLE_WIDTH-1:0]   rd_data_q;

   logic [SAMPLE_WIDTH-1:0]   mem [BUF_DEPTH];

   logic                      flush;
   logic                      wr_allow;
   logic                      wr_en;
   logic                      drop;
   logic                      rd_issue;
   logic [ADDR_W-1:0]         rd_addr;

   // Write-side qualifiers; the read address stays clear of the write
   // address because at least FRAME_LEN samples are held while serving.
   always_comb begin
      flush    = (state_q == IDLE) && !enable_i;
      wr_allow = !flush;
      wr_en    = sample_valid_i && wr_allow && (avail_q != AVAIL_FULL);
      drop     = sample_valid_i && wr_allow && (avail_q == AVAIL_FULL);
      rd_issue = (state_q == SERVE) && win_rd_en_i;
      rd_addr  = base_q + ADDR_W'(offset_q);
   end

   // Pointer, fill-level and sticky overrun next-state.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      base_d    = base_q;
      avail_d   = avail_q;
      overrun_d = (overrun_q && !clear_i) || drop;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         avail_d  = avail_d + AVAIL_W'(1);
      end
      if (state_q == ADVANCE) begin
         base_d  = base_q + ADDR_HOP;
         avail_d = avail_d - AVAIL_HOP;
      end
      if (flush) begin
         wr_ptr_d = '0;
         base_d   = '0;
         avail_d  = '0;
      end
   end

   // FSM next-state, read offset and frame counter.
   always_comb begin
      state_d       = state_q;
      offset_d      = offset_q;
      frame_count_d = frame_count_q;
      win_start_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable_i) state_d = WAIT_FILL;
         end
         WAIT_FILL: begin
            if (!enable_i)                 state_d = IDLE;
            else if (avail_q >= AVAIL_FRAME) state_d = START;
         end
         START: begin
            win_start_o = 1'b1;
            offset_d    = '0;
            state_d     = SERVE;
         end
         SERVE: begin
            if (rd_issue) begin
               offset_d = offset_q + OFF_W'(1);
               if (offset_q == OFF_LAST) state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (win_done_i) begin
               frame_count_d = frame_count_q + 16'd1;
               state_d       = ADVANCE;
            end
         end
         ADVANCE: begin
            state_d = WAIT_FILL;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and read-data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         base_q        <= '0;
         avail_q       <= '0;
         offset_q      <= '0;
         frame_count_q <= '0;
         overrun_q     <= 1'b0;
         rd_valid_q    <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         base_q        <= base_d;
         avail_q       <= avail_d;
         offset_q      <= offset_d;
         frame_count_q <= frame_count_d;
         overrun_q     <= overrun_d;
         rd_valid_q    <= rd_issue;
         if (rd_issue) rd_data_q <= mem[rd_addr];
      end
   end

   // Sample RAM write port; contents are discarded logically via the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= sample_i;
   end

   assign win_valid_to_read_o = rd_valid_q;
   assign win_sample_o        = rd_data_q;
   assign busy_o              = (state_q != IDLE);
   assign frame_count_o       = frame_count_q;
   assign overrun_o           = overrun_q;

endmodule

// File: tb/tb_mfcc_frame_scheduler.sv
// Directed bench for mfcc_frame_scheduler with a sample scoreboard.
module tb_mfcc_frame_scheduler;

   localparam int SW        = 16;
   localparam int FRAME_LEN = 306;
   localparam int HOP_LEN   = 128;
   localparam int BUF_DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable_i = 1'b0;
   logic          clear_i = 1'b0;
   logic [SW-1:0] sample_i = '0;
   logic          sample_valid_i = 1'b0;
   logic          win_start_o;
   logic          win_rd_en_i = 1'b0;
   logic          win_valid_to_read_o;
   logic [SW-1:0] win_sample_o;
   logic          win_done_i = 1'b0;
   logic          busy_o;
   logic [15:0]   frame_count_o;
   logic          overrun_o;

   mfcc_frame_scheduler dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .enable_i            (enable_i),
      .clear_i             (clear_i),
      .sample_i            (sample_i),
      .sample_valid_i      (sample_valid_i),
      .win_start_o         (win_start_o),
      .win_rd_en_i         (win_rd_en_i),
      .win_valid_to_read_o (win_valid_to_read_o),
      .win_sample_o        (win_sample_o),
      .win_done_i          (win_done_i),
      .busy_o              (busy_o),
      .frame_count_o       (frame_count_o),
      .overrun_o           (overrun_o)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   int            beats = 0;
   int            starts = 0;
   int            acks = 0;
   int            beat_mark = 0;
   int            model_drops = 0;
   int            busy_err = 0;
   logic [SW-1:0] next_val = '0;
   bit            first_pending = 1'b0;
   logic [SW-1:0] model_q[$];
   logic [SW-1:0] exp_q[$];
   logic [SW-1:0] first_obs[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Samples the DUT outputs mid-cycle and feeds the scoreboard.
   task automatic monitor();
      logic [SW-1:0] exp_v;
      if (win_start_o) begin
         starts++;
         check("stale_beats", exp_q.size(), 0);
         check("frame_ready", (model_q.size() >= FRAME_LEN), 1);
         if (model_q.size() >= FRAME_LEN)
            for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(model_q[i]);
         first_pending = 1'b1;
      end
      if (win_valid_to_read_o) begin
         beats++;
         check("beat_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("sample", win_sample_o, exp_v);
         end
         if (first_pending) begin
            first_obs.push_back(win_sample_o);
            first_pending = 1'b0;
         end
      end
      if (rst_n && starts > acks && !busy_o) busy_err++;
   endtask

   // Consume the current inputs on the next edge, then observe mid-cycle.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      monitor();
   endtask

   task automatic push_model(input logic [SW-1:0] v);
      if (model_q.size() < BUF_DEPTH) model_q.push_back(v);
      else model_drops++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      enable_i = 1'b0; clear_i = 1'b0; sample_valid_i = 1'b0; sample_i = '0;
      win_rd_en_i = 1'b0; win_done_i = 1'b0;
      exp_q.delete(); model_q.delete(); first_obs.delete();
      first_pending = 1'b0;
      beat_mark = beats; acks = starts; model_drops = 0; next_val = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // rd_mode: 0 idle, 1 continuous, 2 alternate cycles.
   task automatic run(input int nsamp, input int gap, input int rd_mode, input int ack_target,
                      input int en_off_beat, input int max_cyc, input string tag);
      int cyc = 0;
      int sent = 0;
      int acked = 0;
      while ((sent < nsamp || acked < ack_target) && cyc < max_cyc) begin
         sample_valid_i = 1'b0;
         win_done_i = 1'b0;
         if (sent < nsamp && (cyc % gap) == 0) begin
            sample_valid_i = 1'b1;
            sample_i = next_val;
            push_model(next_val);
            next_val++;
            sent++;
         end
         win_rd_en_i = (rd_mode == 1) || (rd_mode == 2 && (cyc % 2) == 0);
         if (en_off_beat >= 0 && (beats - beat_mark) >= en_off_beat) enable_i = 1'b0;
         if (acked < ack_target && (beats - beat_mark) == FRAME_LEN) begin
            win_done_i = 1'b1;
            acked++;
            acks++;
            beat_mark = beats;
            for (int i = 0; i < HOP_LEN; i++) void'(model_q.pop_front());
         end
         tick();
         cyc++;
      end
      check({tag, "_timeout"}, (cyc < max_cyc), 1);
      sample_valid_i = 1'b0;
      win_done_i = 1'b0;
   endtask

   initial begin
      int guard;

      // Reset values.
      #1 rst_n = 1'b0;
      #1;
      check("rst_ctrl", {win_start_o, win_valid_to_read_o, busy_o, overrun_o}, 0);
      check("rst_count", frame_count_o, 0);
      check("rst_sample", win_sample_o, 0);
      check("rst_avail", dut.avail_q, 0);
      do_reset();

      // Fill: start pulse timing and one full in-order frame.
      enable_i = 1'b1;
      for (int i = 0; i < FRAME_LEN; i++) begin
         sample_valid_i = 1'b1;
         sample_i = next_val;
         push_model(next_val);
         next_val++;
         tick();
      end
      sample_valid_i = 1'b0;
      check("fill_start_early", win_start_o, 0);
      tick();
      check("fill_start_pulse", win_start_o, 1);
      tick();
      check("fill_start_width", win_start_o, 0);
      repeat (5) tick();
      check("fill_start_count", starts, 1);
      run(0, 1, 1, 1, -1, 1000, "fill");
      check("fill_beats", beats - beat_mark, 0);
      check("fill_frame_count", frame_count_o, acks);
      check("fill_busy", busy_err, 0);

      // Hop: three acknowledged frames out of 700 samples.
      do_reset();
      enable_i = 1'b1;
      run(700, 1, 1, 3, -1, 3000, "hop");
      win_rd_en_i = 1'b1;
      repeat (400) tick();
      check("hop_frame_count", frame_count_o, 3);
      check("hop_avail", dut.avail_q, model_q.size());
      check("hop_frame2_first", first_obs[1], 1 * HOP_LEN);
      check("hop_frame3_first", first_obs[2], 2 * HOP_LEN);
      check("hop_starts", starts - acks, 1);

      // Wrap: 2000 samples consumed while streaming; frame 8 crosses 1023->0.
      do_reset();
      enable_i = 1'b1;
      run(2000, 3, 1, 14, -1, 8000, "wrap");
      check("wrap_frame_count", frame_count_o, 14);
      check("wrap_base896_first", first_obs[7], 7 * HOP_LEN);
      check("wrap_overrun", overrun_o, 0);

      // Overrun: 1030 samples with the frame never consumed.
      do_reset();
      enable_i = 1'b1;
      run(1030, 1, 0, 0, -1, 2000, "ovr");
      check("ovr_flag", overrun_o, 1);
      check("ovr_avail", dut.avail_q, model_q.size());
      check("ovr_wr_ptr", dut.wr_ptr_q, (1030 - model_drops) % BUF_DEPTH);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check("ovr_cleared", overrun_o, 0);
      tick();
      check("ovr_stays_clear", overrun_o, 0);
      clear_i = 1'b1;
      sample_valid_i = 1'b1;
      sample_i = next_val;
      push_model(next_val);
      tick();
      clear_i = 1'b0;
      sample_valid_i = 1'b0;
      check("ovr_clear_collide", overrun_o, 1);

      // Throttle: alternating rd_en, enable dropped mid-frame.
      do_reset();
      enable_i = 1'b1;
      run(FRAME_LEN, 1, 2, 1, 100, 2000, "thr");
      win_rd_en_i = 1'b0;
      repeat (5) tick();
      check("thr_frame_count", frame_count_o, 1);
      check("thr_idle", busy_o, 0);
      check("thr_avail_flushed", dut.avail_q, 0);
      check("thr_busy", busy_err, 0);
      model_q.delete();

      // Reset mid-SERVE, then a fresh frame.
      do_reset();
      enable_i = 1'b1;
      run(FRAME_LEN, 1, 1, 0, -1, 1000, "rstm");
      guard = 0;
      while ((beats - beat_mark) < 50 && guard < 1000) begin
         tick();
         guard++;
      end
      check("rstm_reach_serve", (guard < 1000), 1);
      rst_n = 1'b0;
      #1;
      check("rstm_ctrl", {win_start_o, win_valid_to_read_o, busy_o, overrun_o}, 0);
      check("rstm_sample", win_sample_o, 0);
      check("rstm_avail", dut.avail_q, 0);
      do_reset();
      enable_i = 1'b1;
      next_val = 16'd1000;
      run(FRAME_LEN, 1, 1, 1, -1, 1000, "rstf");
      check("rstf_first", first_obs[0], 1000);
      check("rstf_frame_count", frame_count_o, 1);
      tick();
      check("rstf_avail", dut.avail_q, model_q.size());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
